maxpool_flatten: RTL

- Streaming 2x2/stride-2 signed max-pool that sits directly upstream of the fully-connected classifier stage.
- Accepts one feature-map pixel per cycle in raster order, 26x26 by default.
- Assembles the pooled 13x13 map into a flattened 169-entry parallel vector.
- Presents that vector with a one-cycle valid pulse, which drives the FC stage's input vector and valid_in directly.

---
 rtl/maxpool_flatten_if.sv | 44 ++++
 rtl/maxpool_flatten.sv | 132 +++++++++++++
 2 files changed

// File: rtl/maxpool_flatten_if.sv
// ---------------------------------------------------------------------------
// maxpool_flatten_if
// Bundles the pixel stream into maxpool_flatten and the flattened pooled
// vector it hands to the fully-connected stage.
//
// Signals:
//   pix_in      signed 16-bit input pixel
//   pix_valid   pix_in is valid this cycle
//   pix_sof     start of frame, qualified by pix_valid (pixel is (0,0))
//   pix_ready   block can accept a pixel this cycle
//   output_vec  N_OUT x 16-bit pooled map, index = (y/2)*(IMG_W/2) + x/2
//   valid_out   one-cycle pulse: output_vec holds a new complete frame
//
// Handshake: a pixel transfers on a rising edge where pix_valid && pix_ready.
// pix_valid while pix_ready=0 is not captured; the producer holds pix_in,
// pix_valid and pix_sof until the transfer edge. valid_out has no back-
// pressure; the consumer samples output_vec in the cycle valid_out is high
// (output_vec then stays stable until the next frame completes).
//
// Modports: master = pixel producer side, slave = maxpool_flatten.
// ---------------------------------------------------------------------------
interface maxpool_flatten_if #(
   parameter int IMG_W = 26,
   parameter int IMG_H = 26
);
   localparam int N_OUT = (IMG_W / 2) * (IMG_H / 2);

   logic signed [15:0]       pix_in;
   logic                     pix_valid;
   logic                     pix_sof;
   logic                     pix_ready;
   logic [N_OUT-1:0][15:0]   output_vec;
   logic                     valid_out;

   modport master (
      output pix_in, pix_valid, pix_sof,
      input  pix_ready, output_vec, valid_out
   );

   modport slave (
      input  pix_in, pix_valid, pix_sof,
      output pix_ready, output_vec, valid_out
   );
endinterface

// File: rtl/maxpool_flatten.sv
// ---------------------------------------------------------------------------
// maxpool_flatten
// Streaming 2x2 / stride-2 signed max-pool. Takes one raster-order pixel per
// cycle of an IMG_W x IMG_H map and assembles the pooled map into a
// flattened parallel vector, announced with a one-cycle valid_out pulse.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   bus        maxpool_flatten_if.slave (pixel stream in, pooled vector out)
//   fsm_state  current FSM state (0 = ACCUM, 1 = EMIT) for observation
//
// Optional feature: define MAXPOOL_RELU_EN to clamp every pooled value to
// max(pooled, 0) before it is stored. Undefined: values pass through signed.
// ---------------------------------------------------------------------------
module maxpool_flatten #(
   parameter int IMG_W = 26,
   parameter int IMG_H = 26
) (
   input  logic                  clk,
   input  logic                  reset,
   maxpool_flatten_if.slave      bus,
   output logic                  fsm_state
);
   localparam int N_OUT = (IMG_W / 2) * (IMG_H / 2);
   localparam int HW    = IMG_W / 2;
   localparam int XW    = $clog2(IMG_W);
   localparam int YW    = $clog2(IMG_H);
   localparam int HXW   = (HW > 1) ? $clog2(HW) : 1;
   localparam int IW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;

   if ((IMG_W % 2) != 0 || IMG_W < 2 || (IMG_H % 2) != 0 || IMG_H < 2) begin : g_bad_size
      $error("maxpool_flatten: IMG_W and IMG_H must be even and >= 2");
   end

   typedef enum logic {ACCUM = 1'b0, EMIT = 1'b1} state_t;

   state_t                 state;
   logic [XW-1:0]          x;
   logic [YW-1:0]          y;
   logic [XW-1:0]          cx;         // column of the pixel on the bus
   logic [YW-1:0]          cy;         // row of the pixel on the bus
   logic [HXW-1:0]         hx;         // pooled column
   logic [IW-1:0]          widx;       // flattened pooled index
   logic                   accept;
   logic                   last_pix;
   logic signed [15:0]     h_reg;
   logic signed [15:0]     hmax;
   logic signed [15:0]     vmax;
   logic signed [15:0]     pooled;
   logic signed [15:0]     line_buf [HW];
   logic [N_OUT-1:0][15:0] work;

   assign fsm_state = state;

   always_comb begin
      accept   = bus.pix_valid && bus.pix_ready;
      // An accepted start-of-frame pixel is (0,0) whatever the counters say.
      cx       = bus.pix_sof ? '0 : x;
      cy       = bus.pix_sof ? '0 : y;
      hx       = HXW'(cx >> 1);
      widx     = IW'(cy >> 1) * IW'(HW) + IW'(hx);
      last_pix = (cx == XW'(IMG_W - 1)) && (cy == YW'(IMG_H - 1));
      hmax     = (bus.pix_in > h_reg) ? bus.pix_in : h_reg;
      vmax     = (line_buf[hx] > hmax) ? line_buf[hx] : hmax;
`ifdef MAXPOOL_RELU_EN
      pooled   = vmax[15] ? 16'sd0 : vmax;
`else
      pooled   = vmax;
`endif
   end

   // Control: position counters, FSM and registered handshake outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= ACCUM;
         bus.pix_ready  <= 1'b1;
         bus.valid_out  <= 1'b0;
         bus.output_vec <= '0;
         x              <= '0;
         y              <= '0;
      end else begin
         case (state)
            ACCUM: begin
               if (accept) begin
                  if (last_pix) begin
                     state         <= EMIT;
                     bus.pix_ready <= 1'b0;
                     bus.valid_out <= 1'b1;
                     // Shadow load; the final window is still being written
                     // into work this edge, so patch it in directly.
                     bus.output_vec       <= work;
                     bus.output_vec[widx] <= pooled;
                     x <= '0;
                     y <= '0;
                  end else if (cx == XW'(IMG_W - 1)) begin
                     x <= '0;
                     y <= cy + 1'b1;
                  end else begin
                     x <= cx + 1'b1;
                     y <= cy;
                  end
               end
            end
            EMIT: begin
               state         <= ACCUM;
               bus.pix_ready <= 1'b1;
               bus.valid_out <= 1'b0;
            end
            default: begin
               state         <= ACCUM;
               bus.pix_ready <= 1'b1;
               bus.valid_out <= 1'b0;
            end
         endcase
      end
   end

   // Datapath: contents are don't-care after reset because every window of
   // a complete frame is rewritten before the shadow copy is taken.
   always_ff @(posedge clk) begin
      if (accept) begin
         if (!cx[0]) begin
            h_reg <= bus.pix_in;
         end else if (!cy[0]) begin
            line_buf[hx] <= hmax;
         end else begin
            work[widx] <= pooled;
         end
      end
   end
endmodule
